// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status and the memory arbiter state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single RAM port; data is favoured
// until STARVE_MAX data grants in a row have completed while an instruction waits.
//
// state | meaning
// IDLE  | no grant; arbitration decision taken on the next edge
// IGNT  | instruction fetch owns the RAM until ACCESS/ERROR/withdrawal
// DGNT  | data read/write owns the RAM until ACCESS/ERROR/withdrawal
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SCNT_MAX = CW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          err_q, err_d;
    logic          dreq, ram_access, ram_error;
    ramstate_t     rs;

    assign rs         = ramstate_t'(ramstate);
    assign dreq       = dREN | dWEN;
    assign ram_access = (rs == ACCESS);
    assign ram_error  = (rs == ERROR);

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!iREN) scnt_d = '0;
                if (dreq && (!iREN || scnt_q < SCNT_MAX)) state_d = DGNT;
                else if (iREN)                             state_d = IGNT;
            end
            IGNT: begin
                // A withdrawn request ends the grant quietly, even if the RAM flags an error.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d = IDLE;
                    scnt_d  = '0;
                end else if (ram_error) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DGNT: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d = IDLE;
                    if (iREN && scnt_q != SCNT_MAX) scnt_d = scnt_q + CW'(1);
                end else if (ram_error) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM enables follow the owning request combinationally so a withdrawal takes effect at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = iREN & ~((state_q == IGNT) & ram_access);
    assign dwait = dreq & ~((state_q == DGNT) & ram_access);
    assign iload = ramload;
    assign dload = ramload;
    assign err   = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks queue expected results, a RAM model
// answers grants, and a per-cycle monitor compares against transaction-level rules.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] DBASE      = 32'h100;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          n_tests = 0, n_fail = 0;
    exp_t        exp_i[$], exp_d[$];
    int          order_q[$];
    ramstate_t   script_q[$];
    bit          hold_busy = 0;
    int          p_err = 10;
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          i_done = 0, d_done = 0;
    int          glen = 0, last_glen = 0, err_count = 0, streak = 0;
    int          rst_cnt = 0, rst_seen = 0;
    logic        en_prev = 0, ireq_prev = 0, dreq_prev = 0, rst_prev = 0, err_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] image(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : image(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : image(a);
    endfunction

    always @(posedge RST) rst_cnt++;

    // RAM model followed by the monitor, both once per cycle on the falling edge.
    always @(negedge CLK) begin : mon
        logic en, dreq, i_srv, d_srv, rst_any, exp_err;
        int   r;
        exp_t e;
        en = ramREN | ramWEN;
        if (en && !RST) begin
            if (hold_busy) ramstate = BUSY;
            else if (script_q.size() > 0) ramstate = script_q.pop_front();
            else begin
                r = $urandom_range(0, 99);
                ramstate = (r < p_err) ? ERROR : (r < 55) ? ACCESS : BUSY;
            end
        end else begin
            ramstate = FREE;
        end
        ramload = (ramstate == ACCESS && ramREN) ? ram_rd(ramaddr) : $urandom;
        #1;
        en      = ramREN | ramWEN;
        dreq    = dREN | dWEN;
        rst_any = RST || (rst_cnt != rst_seen);
        rst_seen = rst_cnt;
        i_done  = 0;
        d_done  = 0;
        if (RST) begin
            check("rst_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
            check("rst_ramaddr", ramaddr, 32'd0);
            check("rst_ramstore", ramstore, 32'd0);
        end
        i_srv = !RST && ramstate == ACCESS && ramREN && !ramWEN && ramaddr == iaddr && ramaddr < DBASE;
        d_srv = !RST && ramstate == ACCESS && en && ramaddr == daddr && ramaddr >= DBASE;
        check("iwait", iwait, iREN && !i_srv);
        check("dwait", dwait, dreq && !d_srv);
        check("iload_follows_ram", iload, ramload);
        check("dload_follows_ram", dload, ramload);
        exp_err = err_pend && !rst_any;
        check("err", err, exp_err);
        if (err) err_count++;
        err_pend = !RST && en && ramstate == ERROR;
        if (rst_any) streak = 0;
        if (en && !en_prev) begin
            glen = 0;
            if (!rst_any) begin
                if (ramaddr < DBASE) begin
                    if (dreq_prev) check("i_grant_needs_streak_max", streak, STARVE_MAX);
                end else if (ireq_prev) begin
                    check("d_grant_streak_below_max", streak < STARVE_MAX, 1);
                end
            end
        end
        if (!en_prev && (ireq_prev || dreq_prev) && !rst_any && !rst_prev)
            check("grant_latency", en, 1);
        if (en) glen++;
        if (!RST && iREN && !iwait) begin
            i_done = 1;
            last_glen = glen;
            if (exp_i.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL i_unexpected: got completion expected none (t=%0t)", $time);
            end else begin
                e = exp_i.pop_front();
                check("i_data", iload, e.data);
                check("i_addr", ramaddr, e.addr);
            end
            order_q.push_back(1);
            streak = 0;
        end
        if (!RST && dreq && !dwait) begin
            d_done = 1;
            if (exp_d.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d_unexpected: got completion expected none (t=%0t)", $time);
            end else begin
                e = exp_d.pop_front();
                check("d_addr", ramaddr, e.addr);
                if (e.wr) begin
                    check("d_wr_enables", {30'd0, ramREN, ramWEN}, 32'd1);
                    check("d_wr_store", ramstore, e.data);
                end else begin
                    check("d_rd_enables", {30'd0, ramREN, ramWEN}, 32'd2);
                    check("d_rd_data", dload, e.data);
                end
            end
            order_q.push_back(2);
            if (iREN) streak++;
        end
        if (!RST && ramstate == ACCESS && ramWEN) ram_mem[ramaddr] = ramstore;
        en_prev   = en;
        ireq_prev = iREN;
        dreq_prev = dreq;
        rst_prev  = RST;
    end

    task automatic wait_done(input bit is_i);
        bit ok = 0;
        n_tests++;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            #2;
            if (is_i ? i_done : d_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_%s: got no completion in 400 cycles expected completion", is_i ? "instr" : "data");
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] a);
        exp_t e;
        e.wr = 0; e.addr = a; e.data = ref_rd(a);
        exp_i.push_back(e);
        iaddr = a;
        iREN  = 1;
        wait_done(1);
        iREN  = 0;
    endtask

    task automatic do_data(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] v);
        exp_t e;
        e.wr = wr; e.addr = a;
        if (wr) begin
            ref_mem[a] = v;
            e.data = v;
            dstore = v;
            dWEN = 1;
            dREN = both;
        end else begin
            e.data = ref_rd(a);
            dWEN = 0;
            dREN = 1;
        end
        exp_d.push_back(e);
        daddr = a;
        wait_done(0);
        dREN = 0;
        dWEN = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_ord[7];
        int e0;
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        idle_cycles(2);
        iREN = 1; dWEN = 1; daddr = 32'h104;
        @(posedge CLK); #1;
        check("rst_iwait_follows_req", iwait, 1);
        check("rst_dwait_follows_req", dwait, 1);
        check("rst_err", err, 0);
        iREN = 0; dWEN = 0;
        @(posedge CLK); #2;
        RST = 0;
        @(posedge CLK); #1;

        // Instruction fetch with two BUSY cycles before ACCESS.
        ram_mem[32'h40] = 32'h8C010004;
        ref_mem[32'h40] = 32'h8C010004;
        script_q = '{BUSY, BUSY, ACCESS};
        do_instr(32'h40);
        check("t1_grant_len", last_glen, 3);
        check("t1_idle_after", ramREN, 0);

        // Simultaneous instruction and data write: data goes first.
        order_q.delete();
        script_q = '{ACCESS, ACCESS};
        fork
            do_instr(32'h80);
            do_data(1, 0, 32'h100, 32'hDEADBEEF);
        join
        check("t2_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("t2_first_data", order_q[0], 2);
            check("t2_then_instr", order_q[1], 1);
        end

        // Starvation limit: six data reads against one held instruction fetch.
        p_err = 0;
        order_q.delete();
        exp_ord = '{2, 2, 2, 2, 1, 2, 2};
        fork
            do_instr(32'h20);
            for (int k = 0; k < 6; k++) do_data(0, 0, DBASE + 32'(4 * k), 32'd0);
        join
        check("t3_count", order_q.size(), 7);
        for (int k = 0; k < 7 && k < order_q.size(); k++) check("t3_order", order_q[k], exp_ord[k]);
        p_err = 10;

        // RAM error during a data write with both enables raised, then read back.
        e0 = err_count;
        script_q = '{BUSY, ERROR, BUSY, ACCESS};
        do_data(1, 1, 32'h1F0, 32'hCAFE0001);
        check("t4_err_pulses", err_count - e0, 1);
        do_data(0, 0, 32'h1F0, 32'd0);

        // Reset in the middle of an instruction grant.
        p_err = 0;
        e0 = err_count;
        hold_busy = 1;
        fork
            do_instr(32'h44);
            begin
                idle_cycles(3);
                RST = 1;
                #1;
                check("t5_ramREN_dropped", ramREN, 0);
                check("t5_iwait_held", iwait, 1);
                @(posedge CLK); #2;
                RST = 0;
                hold_busy = 0;
            end
        join
        check("t5_no_err", err_count - e0, 0);
        p_err = 10;

        // Data requester withdraws while the RAM is busy.
        hold_busy = 1;
        daddr = 32'h120;
        dREN = 1;
        idle_cycles(3);
        dREN = 0;
        #1;
        check("t6_ramREN_dropped", ramREN, 0);
        check("t6_dwait", dwait, 0);
        @(posedge CLK); #1;
        hold_busy = 0;
        check("t6_idle_addr", ramaddr, 0);
        do_instr(32'h10);

        // Randomized mixed traffic.
        fork
            for (int k = 0; k < 40; k++) begin
                idle_cycles($urandom_range(0, 3));
                do_instr(32'(4 * $urandom_range(0, 63)));
            end
            for (int k = 0; k < 80; k++) begin
                idle_cycles($urandom_range(0, 2));
                do_data(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        DBASE + 32'(4 * $urandom_range(0, 15)), $urandom);
            end
        join
        idle_cycles(2);
        check("drain_instr_queue", exp_i.size(), 0);
        check("drain_data_queue", exp_d.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4; maximum consecutive data grants while an instruction request waits.
REQ-002 SHALL have ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction byte address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data byte address
- dstore  in  32  data write value
- iwait  out  1  instruction request not completing this cycle
- dwait  out  1  data request not completing this cycle
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR
- err  out  1  one-cycle pulse on an aborted transaction

Function
REQ-003 SHALL implement FSM states IDLE, IGNT, DGNT.
REQ-004 IDLE: dreq=dREN|dWEN. If dreq and (!iREN or scnt<STARVE_MAX), go to DGNT. Else if iREN, go to IGNT. Else stay in IDLE.
REQ-005 Arbitration latency SHALL be one cycle: a request first seen in IDLE at edge t drives RAM enables from cycle t+1.
REQ-006 IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr. DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. IDLE: all RAM outputs 0.
REQ-007 If dREN and dWEN are both high, ramWEN SHALL win and ramREN SHALL be forced to 0.
REQ-008 A grant SHALL be held, with no preemption, until ramstate==ACCESS. The FSM then returns to IDLE on the next edge.
REQ-009 iwait SHALL be 0 only when state==IGNT and ramstate==ACCESS. Otherwise it is 1 whenever iREN=1. It is 0 when iREN=0.
REQ-010 dwait SHALL follow the same rule for DGNT and dreq.
REQ-011 iload and dload SHALL equal ramload combinationally in all states. They are valid only in the completing cycle.
REQ-012 scnt SHALL be a saturating counter of width $clog2(STARVE_MAX+1):
- increments on each DGNT completion while iREN=1;
- clears on IGNT completion, or when iREN=0 in IDLE.
REQ-013 Requester withdrawal: if the granted request drops before ACCESS, the FSM SHALL return to IDLE on the next edge. RAM enables follow the request combinationally and deassert in the withdrawal cycle. No err is raised.
REQ-014 ramstate==ERROR in IGNT or DGNT SHALL:
- return the FSM to IDLE;
- pulse err for one cycle (registered);
- keep the requester's wait at 1.
The requester may retry.
REQ-015 ramstate FREE or BUSY SHALL leave the grant unchanged.
REQ-016 When a data request and an instruction request are both pending with scnt<STARVE_MAX, data SHALL win. With scnt==STARVE_MAX, instruction SHALL win.

Reset
REQ-017 RST=1 SHALL asynchronously force state=IDLE, scnt=0 and err=0.
REQ-018 Consequently, during reset ramREN=ramWEN=0, ramaddr=0, ramstore=0, and iwait/dwait equal their request inputs.
REQ-019 Reset asserted mid-grant SHALL abort the transaction with no err pulse. Behaviour after release is as from power-up.

Structure
REQ-020 SHALL place the ramstate enum (FREE, BUSY, ACCESS, ERROR) and the arbiter state enum in the shared cpu types package.
REQ-021 SHALL be a single module with no sub-modules. The counter and FSM are inline.

Verification
REQ-022 Case: iREN only, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C010004. Required: ramREN high for 3 cycles, iwait=0 and iload=0x8C010004 in the 3rd, then IDLE.
REQ-023 Case: iREN and dWEN raised together, daddr=0x100, dstore=0xDEADBEEF. Required: DGNT first with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; IGNT after completion plus one IDLE cycle.
REQ-024 Case: iREN held with 6 back-to-back dREN requests, STARVE_MAX=4. Required: 4 data grants, then 1 instruction grant, then the remaining data grants.
REQ-025 Case: ramstate=ERROR during DGNT. Required: err=1 for exactly one cycle, dwait stays 1, the retry completes on a later ACCESS.
REQ-026 Case: RST pulsed while in IGNT with ramstate=BUSY. Required: ramREN=0 in the same cycle, state=IDLE, no err pulse, clean grant after release.
REQ-027 Case: dREN dropped mid-DGNT. Required: ramREN=0 in that cycle, IDLE on the next edge, dwait=0.
